// File: rtl/pwr_domain_sequencer.sv
// rtl/pwr_domain_sequencer.sv - power-gating sequencer for one switchable domain
//
// Purpose: answers a four-phase power-down request from always-on control and
// sequences clock gate, isolation, retention save and power switch-off (and the
// reverse on power-up). All outputs are a registered Moore decode of the state.
//
// Ports:
//   clk          single clock
//   rst_n        synchronous active-low reset
//   pwr_down_req level request, 1 = domain down, 0 = domain up
//   pwr_sw_ack   power-switch status, 1 = rail good, 0 = rail off
//   pwr_down_ack four-phase acknowledge, 1 = domain is off
//   clk_en       clock enable to the gated domain
//   iso_en       isolation enable on the domain outputs
//   ret_save     one-cycle retention save pulse
//   ret_restore  one-cycle retention restore pulse
//   pwr_sw_en    power-switch enable, 1 = on
//   fault        sticky switch-timeout flag
//   state        current state encoding, for debug
module pwr_domain_sequencer #(
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwr_down_req,
    input  logic       pwr_sw_ack,
    output logic       pwr_down_ack,
    output logic       clk_en,
    output logic       iso_en,
    output logic       ret_save,
    output logic       ret_restore,
    output logic       pwr_sw_en,
    output logic       fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_ON      = 4'd0,
        ST_CLK_OFF = 4'd1,
        ST_ISO     = 4'd2,
        ST_SAVE    = 4'd3,
        ST_PSW_OFF = 4'd4,
        ST_OFF     = 4'd5,
        ST_PSW_ON  = 4'd6,
        ST_RESTORE = 4'd7,
        ST_DEISO   = 4'd8,
        ST_CLK_ON  = 4'd9,
        ST_FAULT   = 4'd10
    } state_t;

    // cnt_q holds the number of cycles already spent in the current state,
    // so a state of length N is left when cnt_q reaches N-1.
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              clk_en_q, clk_en_d;
    logic              iso_en_q, iso_en_d;
    logic              ret_save_q, ret_save_d;
    logic              ret_restore_q, ret_restore_d;
    logic              pwr_sw_en_q, pwr_sw_en_d;
    logic              pwr_down_ack_q, pwr_down_ack_d;
    logic              fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ON:      if (pwr_down_req)         state_d = ST_CLK_OFF;
            ST_CLK_OFF: if (cnt_q == SETTLE_LAST) state_d = ST_ISO;
            ST_ISO:     if (cnt_q == SETTLE_LAST) state_d = ST_SAVE;
            ST_SAVE:                              state_d = ST_PSW_OFF;
            // A matching acknowledge wins over the timeout in the same cycle.
            ST_PSW_OFF: begin
                if (!pwr_sw_ack)                  state_d = ST_OFF;
                else if (cnt_q == TIMEOUT_LAST)   state_d = ST_FAULT;
            end
            ST_OFF:     if (!pwr_down_req)        state_d = ST_PSW_ON;
            ST_PSW_ON: begin
                if (pwr_sw_ack)                   state_d = ST_RESTORE;
                else if (cnt_q == TIMEOUT_LAST)   state_d = ST_FAULT;
            end
            ST_RESTORE:                           state_d = ST_DEISO;
            ST_DEISO:   if (cnt_q == SETTLE_LAST) state_d = ST_CLK_ON;
            ST_CLK_ON:  if (cnt_q == SETTLE_LAST) state_d = ST_ON;
            ST_FAULT:                             state_d = ST_FAULT;
            // Unused encodings park in the isolated, switched-off fault state.
            default:                              state_d = ST_FAULT;
        endcase

        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        else                     cnt_d = cnt_q;

        // Outputs decode the next state so they are registered alongside it.
        clk_en_d       = 1'b0;
        iso_en_d       = 1'b1;
        ret_save_d     = 1'b0;
        ret_restore_d  = 1'b0;
        pwr_sw_en_d    = 1'b1;
        pwr_down_ack_d = 1'b0;
        fault_d        = 1'b0;
        unique case (state_d)
            ST_ON:      begin clk_en_d = 1'b1; iso_en_d = 1'b0; end
            ST_CLK_OFF: iso_en_d = 1'b0;
            ST_ISO:     ;
            ST_SAVE:    ret_save_d = 1'b1;
            ST_PSW_OFF: pwr_sw_en_d = 1'b0;
            ST_OFF:     begin pwr_sw_en_d = 1'b0; pwr_down_ack_d = 1'b1; end
            ST_PSW_ON:  ;
            ST_RESTORE: ret_restore_d = 1'b1;
            ST_DEISO:   iso_en_d = 1'b0;
            ST_CLK_ON:  begin clk_en_d = 1'b1; iso_en_d = 1'b0; end
            default:    begin pwr_sw_en_d = 1'b0; fault_d = 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_ON;
            cnt_q          <= '0;
            clk_en_q       <= 1'b1;
            iso_en_q       <= 1'b0;
            ret_save_q     <= 1'b0;
            ret_restore_q  <= 1'b0;
            pwr_sw_en_q    <= 1'b1;
            pwr_down_ack_q <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            clk_en_q       <= clk_en_d;
            iso_en_q       <= iso_en_d;
            ret_save_q     <= ret_save_d;
            ret_restore_q  <= ret_restore_d;
            pwr_sw_en_q    <= pwr_sw_en_d;
            pwr_down_ack_q <= pwr_down_ack_d;
            fault_q        <= fault_d;
        end
    end

    assign state        = state_q;
    assign clk_en       = clk_en_q;
    assign iso_en       = iso_en_q;
    assign ret_save     = ret_save_q;
    assign ret_restore  = ret_restore_q;
    assign pwr_sw_en    = pwr_sw_en_q;
    assign pwr_down_ack = pwr_down_ack_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_pwr_domain_sequencer.sv
// tb/tb_pwr_domain_sequencer.sv - scoreboard bench for pwr_domain_sequencer
module tb_pwr_domain_sequencer;

    localparam int S = 2;
    localparam int T = 16;

    localparam int ON = 0, CLK_OFF = 1, ISO = 2, SAVE = 3, PSW_OFF = 4, OFF = 5;
    localparam int PSW_ON = 6, RESTORE = 7, DEISO = 8, CLK_ON = 9, FAULT = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwr_down_req = 1'b0;
    logic       pwr_sw_ack = 1'b1;
    logic       pwr_down_ack, clk_en, iso_en, ret_save, ret_restore, pwr_sw_en, fault;
    logic [3:0] state;

    int n_vec = 0;
    int n_err = 0;
    int expq[$];

    pwr_domain_sequencer #(.SETTLE_CYC(S), .TIMEOUT_CYC(T), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .pwr_down_req(pwr_down_req), .pwr_sw_ack(pwr_sw_ack),
        .pwr_down_ack(pwr_down_ack), .clk_en(clk_en), .iso_en(iso_en),
        .ret_save(ret_save), .ret_restore(ret_restore), .pwr_sw_en(pwr_sw_en),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    // Output table per state: {clk_en, iso_en, ret_save, ret_restore, pwr_sw_en, pwr_down_ack, fault}
    function automatic logic [6:0] exp_outs(input int st);
        case (st)
            ON:      return 7'b1000100;
            CLK_OFF: return 7'b0000100;
            ISO:     return 7'b0100100;
            SAVE:    return 7'b0110100;
            PSW_OFF: return 7'b0100000;
            OFF:     return 7'b0100010;
            PSW_ON:  return 7'b0100100;
            RESTORE: return 7'b0101100;
            DEISO:   return 7'b0000100;
            CLK_ON:  return 7'b1000100;
            default: return 7'b0100001;
        endcase
    endfunction

    // Monitor: every cycle the DUT presents a new state/output set.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            int e;
            logic [10:0] got, want;
            e = expq.pop_front();
            got  = {state, clk_en, iso_en, ret_save, ret_restore, pwr_sw_en, pwr_down_ack, fault};
            want = {4'(e), exp_outs(e)};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL vec%0d: got state=%0d outs=%b, want state=%0d outs=%b",
                         n_vec, got[10:7], got[6:0], want[10:7], want[6:0]);
            end
        end
    end

    // One clock of stimulus; nxt is the state the model expects after the edge.
    task automatic cyc(input logic req, input logic ack, input logic rstn, input int nxt);
        pwr_down_req = req;
        pwr_sw_ack   = ack;
        rst_n        = rstn;
        @(posedge clk);
        #1;
        expq.push_back(nxt);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(rb(), rb(), 1'b0, ON);
    endtask

    // A state of fixed length: requests and switch status are ignored inside it.
    task automatic run_state(input int st, input int dur, input int nxt);
        for (int i = 0; i < dur; i++) cyc(rb(), rb(), 1'b1, (i == dur - 1) ? nxt : st);
    endtask

    // Wait for the switch: acknowledge matches after d cycles, timeout after T.
    task automatic run_psw(input int st, input logic idle_ack, input int d,
                           input int nxt, output logic faulted);
        faulted = 1'b0;
        for (int i = 0; i < T; i++) begin
            if (i == d) begin
                cyc(rb(), ~idle_ack, 1'b1, nxt);
                return;
            end
            cyc(rb(), idle_ack, 1'b1, (i == T - 1) ? FAULT : st);
        end
        faulted = 1'b1;
    endtask

    task automatic dwell(input int st, input logic hold_req, input int n);
        for (int i = 0; i < n; i++) cyc(hold_req, rb(), 1'b1, st);
    endtask

    // From ON: down to OFF (or FAULT). abort_save resets while in SAVE.
    task automatic go_down(input int d, input logic abort_save, output logic faulted);
        faulted = 1'b0;
        cyc(1'b1, rb(), 1'b1, CLK_OFF);
        run_state(CLK_OFF, S, ISO);
        run_state(ISO, S, SAVE);
        if (abort_save) begin
            do_reset(1);
            return;
        end
        run_state(SAVE, 1, PSW_OFF);
        run_psw(PSW_OFF, 1'b1, d, OFF, faulted);
    endtask

    // From OFF: up to ON (or FAULT).
    task automatic go_up(input int d, output logic faulted);
        faulted = 1'b0;
        cyc(1'b0, rb(), 1'b1, PSW_ON);
        run_psw(PSW_ON, 1'b0, d, RESTORE, faulted);
        if (faulted) return;
        run_state(RESTORE, 1, DEISO);
        run_state(DEISO, S, CLK_ON);
        run_state(CLK_ON, S, ON);
    endtask

    initial begin
        logic f;
        do_reset(2);

        // Directed: immediate ack down, 5-cycle PSW_ON up, 1-cycle-late ack down.
        dwell(ON, 1'b0, 1);
        go_down(0, 1'b0, f);
        dwell(OFF, 1'b1, 2);
        go_up(4, f);
        go_down(1, 1'b0, f);
        // Reversed request already low at first OFF cycle: OFF lasts one cycle.
        go_up(0, f);

        // Randomized sequences.
        for (int k = 0; k < 20; k++) begin
            dwell(ON, 1'b0, $urandom_range(0, 3));
            go_down($urandom_range(0, 5), 1'b0, f);
            dwell(OFF, 1'b1, $urandom_range(0, 3));
            go_up($urandom_range(0, 5), f);
        end

        // Acknowledge on the last allowed cycle still succeeds.
        go_down(T - 1, 1'b0, f);
        go_up(T - 1, f);

        // Switch never drops: FAULT is sticky until reset.
        go_down(1000, 1'b0, f);
        for (int i = 0; i < 6; i++) cyc(rb(), rb(), 1'b1, FAULT);
        do_reset(1);

        // Switch never rises on power-up.
        go_down(0, 1'b0, f);
        go_up(1000, f);
        for (int i = 0; i < 4; i++) cyc(rb(), rb(), 1'b1, FAULT);
        do_reset(1);

        // Reset while in SAVE.
        go_down(0, 1'b1, f);
        dwell(ON, 1'b0, 2);

        @(negedge clk);
        #1;
        n_vec++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
